// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: stage indices,
//   the scoreboard entry layout and the forward-select width helper.
//   Configuration macro used by the controller: PIPE_FORWARDING_EN.
// ----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   // Fixed front-end stage indices; stages past MEM are parameter dependent.
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;

   // Widest register address the scoreboard can hold; narrower register files
   // zero-extend into it, so the unused upper bits are constant zero.
   localparam int RD_W_MAX = 16;

   typedef struct packed {
      logic                valid;
      logic [RD_W_MAX-1:0] rd;
      logic                regwrite;
      logic                load;
   } sb_entry_t;

   // Forward codes run 0..STAGES-3, so this width always covers them.
   function automatic int fw_width(input int stages);
      return $clog2(stages - 1);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundle between the pipeline datapath (master) and the hazard controller
//   (slave).
//   master drives : id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
//                   id_rd_i, id_regwrite_i, id_load_i, branch_taken_i,
//                   ext_stall_i
//   slave drives  : pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
//                   fwd_rs_o, fwd_rt_o, stall_cnt_o
//   STAGES must match the controller instance so the forward codes line up.
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int STAGES = 5,
   parameter int REG_AW = 5
);
   localparam int FW_W = fw_width(STAGES);

   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs_i;
   logic [REG_AW-1:0] id_rt_i;
   logic              id_use_rs_i;
   logic              id_use_rt_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_regwrite_i;
   logic              id_load_i;
   logic              branch_taken_i;
   logic              ext_stall_i;

   logic              pc_write_o;
   logic              if_id_write_o;
   logic              if_id_flush_o;
   logic              id_ex_bubble_o;
   logic [FW_W-1:0]   fwd_rs_o;
   logic [FW_W-1:0]   fwd_rt_o;
   logic [31:0]       stall_cnt_o;

   modport master (
      output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
             id_rd_i, id_regwrite_i, id_load_i, branch_taken_i, ext_stall_i,
      input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
             fwd_rs_o, fwd_rt_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
             id_rd_i, id_regwrite_i, id_load_i, branch_taken_i, ext_stall_i,
      output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
             fwd_rs_o, fwd_rt_o, stall_cnt_o
   );

endinterface

// File: rtl/pipe_hazard_ctrl_src_match.sv
// ----------------------------------------------------------------------------
// hazard_src_match
//   Finds the youngest in-flight writer of one ID source register.
//   Ports:
//     use_src  in  source is actually read by the ID instruction
//     src      in  source register address (r0 never matches)
//     sb       in  scoreboard entries for stages EX..WB (index 2..STAGES-1)
//     hit      out some in-flight writer targets src
//     pos      out stage index of the youngest such writer
//     load     out that writer is a load
// ----------------------------------------------------------------------------
module hazard_src_match
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int STAGES = 5,
   parameter int REG_AW = 5
) (
   input  logic                      use_src,
   input  logic [REG_AW-1:0]         src,
   input  sb_entry_t                 sb [2:STAGES-1],
   output logic                      hit,
   output logic [$clog2(STAGES)-1:0] pos,
   output logic                      load
);

   always_comb begin
      // NOTE: every output gets a default before the loop; a path that leaves
      // one unassigned would infer a latch.
      hit  = 1'b0;
      pos  = '0;
      load = 1'b0;
      // Walk oldest to youngest so the last hit written is the youngest.
      for (int p = STAGES - 1; p >= 2; p--) begin
         if (use_src && (src != '0) && sb[p].valid && sb[p].regwrite &&
             (sb[p].rd == RD_W_MAX'(src))) begin
            hit  = 1'b1;
            pos  = ($clog2(STAGES))'(p);
            load = sb[p].load;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard / stall / flush controller for an in-order pipeline of STAGES
//   stages (0=IF, 1=ID, 2=EX, 3=MEM, ..., STAGES-1=WB). A shadow scoreboard
//   tracks in-flight writers EX..WB and resolves RAW hazards for the ID
//   instruction: forward selects, load-use stalls, branch flush, ext freeze.
//   Ports:
//     clk_i  in  clock
//     rst_i  in  asynchronous reset, active high
//     bus    slave side of pipe_hazard_ctrl_if (ID info in, controls out)
//   Macro PIPE_FORWARDING_EN: when defined, results are forwarded from EX+
//   and only young loads stall; otherwise forward codes are 0 and any
//   consumer waits until its producer reaches WB.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter  int STAGES   = 5,
   parameter  int REG_AW   = 5,
   parameter  int LOAD_LAT = 1,
   localparam int FW_W     = fw_width(STAGES)
) (
   input logic               clk_i,
   input logic               rst_i,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int PW = $clog2(STAGES);

   if (STAGES < 5 || LOAD_LAT < 1 || LOAD_LAT > STAGES - 4 ||
       REG_AW > RD_W_MAX) begin : g_bad_cfg
      $error("pipe_hazard_ctrl: unsupported STAGES/LOAD_LAT/REG_AW");
   end

   sb_entry_t       sb [2:STAGES-1];
   logic            rs_hit, rt_hit, rs_load, rt_load;
   logic [PW-1:0]   rs_pos, rt_pos;
   logic            rs_hz, rt_hz, hz;
   logic [FW_W-1:0] fwd_rs, fwd_rt;
   logic [31:0]     stall_cnt;

   hazard_src_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match_rs (
      .use_src (bus.id_use_rs_i),
      .src     (bus.id_rs_i),
      .sb      (sb),
      .hit     (rs_hit),
      .pos     (rs_pos),
      .load    (rs_load)
   );

   hazard_src_match #(.STAGES(STAGES), .REG_AW(REG_AW)) u_match_rt (
      .use_src (bus.id_use_rt_i),
      .src     (bus.id_rt_i),
      .sb      (sb),
      .hit     (rt_hit),
      .pos     (rt_pos),
      .load    (rt_load)
   );

`ifdef PIPE_FORWARDING_EN
   // A load result becomes forwardable once it is LOAD_LAT stages past MEM;
   // a younger load must hold ID. A WB match reads through the register file.
   assign rs_hz  = rs_hit && rs_load && (int'(rs_pos) + 1 < 3 + LOAD_LAT);
   assign rt_hz  = rt_hit && rt_load && (int'(rt_pos) + 1 < 3 + LOAD_LAT);
   assign fwd_rs = (rs_hit && int'(rs_pos) != STAGES - 1) ?
                   FW_W'(int'(rs_pos) - 1) : '0;
   assign fwd_rt = (rt_hit && int'(rt_pos) != STAGES - 1) ?
                   FW_W'(int'(rt_pos) - 1) : '0;
`else
   // No bypass network: any producer not yet in WB blocks the consumer.
   logic unused_load;
   assign unused_load = rs_load | rt_load;
   assign rs_hz  = rs_hit && (int'(rs_pos) <= STAGES - 2);
   assign rt_hz  = rt_hit && (int'(rt_pos) <= STAGES - 2);
   assign fwd_rs = '0;
   assign fwd_rt = '0;
`endif

   assign hz = bus.id_valid_i && (rs_hz || rt_hz);

   // Scoreboard advances with the pipeline; a stalled or empty ID slot enters
   // EX as a bubble. The valid bits must start cleared, so every entry resets.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 2; p < STAGES; p++) sb[p] <= '0;
         stall_cnt <= '0;
      end else if (!bus.ext_stall_i) begin
         // NOTE: sequential state uses non-blocking assignments so the shift
         // reads every entry's old value regardless of statement order.
         sb[2] <= (bus.id_valid_i && !hz) ?
                  sb_entry_t'{valid:    1'b1,
                              rd:       RD_W_MAX'(bus.id_rd_i),
                              regwrite: bus.id_regwrite_i,
                              load:     bus.id_load_i} : '0;
         for (int p = 3; p < STAGES; p++) sb[p] <= sb[p-1];
         if (hz && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   // Priority: external freeze, then hazard stall, then branch flush. A stall
   // suppresses the flush; the branch is re-evaluated once ID is released.
   always_comb begin
      bus.pc_write_o     = 1'b1;
      bus.if_id_write_o  = 1'b1;
      bus.if_id_flush_o  = 1'b0;
      bus.id_ex_bubble_o = 1'b0;
      if (bus.ext_stall_i) begin
         bus.pc_write_o    = 1'b0;
         bus.if_id_write_o = 1'b0;
      end else if (hz) begin
         bus.pc_write_o     = 1'b0;
         bus.if_id_write_o  = 1'b0;
         bus.id_ex_bubble_o = 1'b1;
      end else begin
         bus.if_id_flush_o = bus.branch_taken_i && bus.id_valid_i;
      end
   end

   assign bus.fwd_rs_o    = fwd_rs;
   assign bus.fwd_rt_o    = fwd_rt;
   assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed vectors for pipe_hazard_ctrl: instance a is STAGES=5/LOAD_LAT=1,
//   instance b is STAGES=7/LOAD_LAT=2. Expected values are hand-derived for
//   both builds (with and without PIPE_FORWARDING_EN).
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
   localparam logic [3:0] C_RUN   = 4'b1100;
   localparam logic [3:0] C_FLUSH = 4'b1110;
   localparam logic [3:0] C_STALL = 4'b0001;
   localparam logic [3:0] C_FRZ   = 4'b0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.STAGES(5), .REG_AW(5)) a_if ();
   pipe_hazard_ctrl_if #(.STAGES(7), .REG_AW(5)) b_if ();

   pipe_hazard_ctrl #(.STAGES(5), .REG_AW(5), .LOAD_LAT(1)) u_dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (a_if)
   );

   pipe_hazard_ctrl #(.STAGES(7), .REG_AW(5), .LOAD_LAT(2)) u_dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b_if)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // v, rs, use_rs, rt, use_rt, rd, regwrite, load, branch_taken, ext_stall
   task automatic drv_a(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] rd, input logic rw, input logic ld,
                        input logic br, input logic ex);
      a_if.id_valid_i = v;   a_if.id_rs_i = rs; a_if.id_use_rs_i = urs;
      a_if.id_rt_i = rt;     a_if.id_use_rt_i = urt;
      a_if.id_rd_i = rd;     a_if.id_regwrite_i = rw; a_if.id_load_i = ld;
      a_if.branch_taken_i = br; a_if.ext_stall_i = ex;
      #2;
   endtask

   task automatic drv_b(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rd, input logic rw, input logic ld);
      b_if.id_valid_i = v;   b_if.id_rs_i = rs; b_if.id_use_rs_i = urs;
      b_if.id_rt_i = '0;     b_if.id_use_rt_i = 1'b0;
      b_if.id_rd_i = rd;     b_if.id_regwrite_i = rw; b_if.id_load_i = ld;
      b_if.branch_taken_i = 1'b0; b_if.ext_stall_i = 1'b0;
      #2;
   endtask

   function automatic logic [3:0] ctl_a();
      return {a_if.pc_write_o, a_if.if_id_write_o,
              a_if.if_id_flush_o, a_if.id_ex_bubble_o};
   endfunction

   function automatic logic [3:0] ctl_b();
      return {b_if.pc_write_o, b_if.if_id_write_o,
              b_if.if_id_flush_o, b_if.id_ex_bubble_o};
   endfunction

   task automatic chk_a(input string tag, input logic [3:0] ctl,
                        input logic [31:0] frs, input logic [31:0] frt,
                        input logic [31:0] cnt);
      check({tag, ".ctl"}, 32'(ctl_a()), 32'(ctl));
      check({tag, ".frs"}, 32'(a_if.fwd_rs_o), frs);
      check({tag, ".frt"}, 32'(a_if.fwd_rt_o), frt);
      check({tag, ".cnt"}, a_if.stall_cnt_o, cnt);
   endtask

   task automatic chk_b(input string tag, input logic [3:0] ctl,
                        input logic [31:0] frs, input logic [31:0] cnt);
      check({tag, ".ctl"}, 32'(ctl_b()), 32'(ctl));
      check({tag, ".frs"}, 32'(b_if.fwd_rs_o), frs);
      check({tag, ".cnt"}, b_if.stall_cnt_o, cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0, 0);
      chk_a("rst_a", C_RUN, 0, 0, 0);
      chk_b("rst_b", C_RUN, 0, 0);
      step();
      rst = 1'b0;

      // ALU r3 in EX, ID reads r3
      drv_a(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      chk_a("alu_issue", C_RUN, 0, 0, 0);
      step();
      drv_a(1, 3, 1, 0, 0, 9, 1, 0, 0, 0);
`ifdef PIPE_FORWARDING_EN
      chk_a("alu_fwd", C_RUN, 1, 0, 0);
      step();
`else
      chk_a("alu_st1", C_STALL, 0, 0, 0);
      step();
      chk_a("alu_st2", C_STALL, 0, 0, 1);
      step();
      chk_a("alu_go", C_RUN, 0, 0, 2);
      step();
`endif

      // Load r5 in EX, ID reads rt=r5
      drv_a(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
`ifdef PIPE_FORWARDING_EN
      chk_a("ld_issue", C_RUN, 0, 0, 0);
      step();
      drv_a(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      chk_a("ld_st1", C_STALL, 0, 1, 0);
      step();
      chk_a("ld_fwd", C_RUN, 0, 2, 1);
      step();
`else
      chk_a("ld_issue", C_RUN, 0, 0, 2);
      step();
      drv_a(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      chk_a("ld_st1", C_STALL, 0, 0, 2);
      step();
      chk_a("ld_st2", C_STALL, 0, 0, 3);
      step();
      chk_a("ld_go", C_RUN, 0, 0, 4);
      step();
`endif

      // r0 writer then r0 reader with taken branch
      drv_a(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step();
      drv_a(1, 0, 1, 0, 1, 0, 0, 0, 1, 0);
`ifdef PIPE_FORWARDING_EN
      chk_a("r0_br", C_FLUSH, 0, 0, 1);
`else
      chk_a("r0_br", C_FLUSH, 0, 0, 4);
`endif
      step();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("br_invalid.ctl", 32'(ctl_a()), 32'(C_RUN));
      step();

      // Load-use with taken branch and an external freeze pulse
      drv_a(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
      step();
      drv_a(1, 6, 1, 0, 0, 0, 0, 0, 1, 1);
`ifdef PIPE_FORWARDING_EN
      chk_a("frz", C_FRZ, 1, 0, 1);
      step();
      drv_a(1, 6, 1, 0, 0, 0, 0, 0, 1, 0);
      chk_a("frz_st", C_STALL, 1, 0, 1);
      step();
      chk_a("frz_flush", C_FLUSH, 2, 0, 2);
      step();
`else
      chk_a("frz", C_FRZ, 0, 0, 4);
      step();
      drv_a(1, 6, 1, 0, 0, 0, 0, 0, 1, 0);
      chk_a("frz_st1", C_STALL, 0, 0, 4);
      step();
      chk_a("frz_st2", C_STALL, 0, 0, 5);
      step();
      chk_a("frz_flush", C_FLUSH, 0, 0, 6);
      step();
`endif

      // Older ALU r8 behind younger load r8; reset lands mid-stall
      drv_a(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
      step();
      drv_a(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
      step();
      drv_a(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_FORWARDING_EN
      chk_a("young_ld", C_STALL, 1, 0, 2);
`else
      chk_a("young_ld", C_STALL, 0, 0, 6);
`endif
      rst = 1'b1;
      #1;
      chk_a("rst_mid", C_RUN, 0, 0, 0);
      step();
      rst = 1'b0;

      // WB match reads through the register file
      drv_a(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      step();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drv_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drv_a(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
      chk_a("wb_thru", C_RUN, 0, 0, 0);
      step();

      // Empty ID slot never stalls, even on a matching source
      drv_a(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
      step();
      drv_a(0, 11, 1, 0, 0, 0, 0, 0, 0, 0);
      check("inv_nohz.ctl", 32'(ctl_a()), 32'(C_RUN));
      step();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // STAGES=7, LOAD_LAT=2: load r4 in EX, ID reads r4
      drv_b(1, 0, 0, 4, 1, 1);
      chk_b("b_issue", C_RUN, 0, 0);
      step();
      drv_b(1, 4, 1, 0, 0, 0);
`ifdef PIPE_FORWARDING_EN
      chk_b("b_st1", C_STALL, 1, 0);
      step();
      chk_b("b_st2", C_STALL, 2, 1);
      step();
      chk_b("b_fwd", C_RUN, 3, 2);
      step();
`else
      for (int i = 0; i < 4; i++) begin
         chk_b($sformatf("b_st%0d", i + 1), C_STALL, 0, 32'(i));
         step();
      end
      chk_b("b_go", C_RUN, 0, 4);
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
